// File: rtl/seg7_display_sched.sv
// Display scheduler for the PiFan 4-digit 7-segment interface: arbitrates two
// valid/ready sources on a scan-count dwell and converts each value to BCD.
module seg7_display_sched #(
  parameter int unsigned SCAN_DIV    = 24000,
  parameter int unsigned DWELL_SCANS = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [13:0] a_value,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [13:0] b_value,
  output logic        b_ready,
  output logic        scan_enable,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [1:0]  colon,
  output logic        src,
  output logic        busy
);

  localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
  localparam int unsigned DWELL_W = (DWELL_SCANS > 1) ? $clog2(DWELL_SCANS) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_SCANS - 1);
  localparam logic [13:0]        VAL_MAX    = 14'd9999;

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_CONV, ST_COMMIT} state_t;

  state_t              r_state, w_state_next;
  logic [SCAN_W-1:0]   r_scan_cnt;
  logic                r_scan_en;
  logic [13:0]         r_val_a, r_val_b;
  logic                r_pend_a, r_pend_b;
  logic                r_has_a, r_has_b;
  logic                r_a_ready, r_b_ready;
  logic                r_sel;
  logic [29:0]         r_shift;
  logic [3:0]          r_bit_cnt;
  logic [DWELL_W-1:0]  r_dwell, w_dwell_next;
  logic [15:0]         r_digits;
  logic [1:0]          r_colon;
  logic                r_src;

  logic w_cap_a, w_cap_b;
  logic w_load, w_load_src;
  logic w_pend_a_next, w_pend_b_next;
  logic w_pend_sel, w_has_other;

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  function automatic logic [29:0] f_dd_step(input logic [29:0] s);
    logic [29:0] t;
    t = s;
    for (int unsigned i = 0; i < 4; i++) begin
      if (t[14 + 4*i +: 4] >= 4'd5) t[14 + 4*i +: 4] = t[14 + 4*i +: 4] + 4'd3;
    end
    return {t[28:0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_scan_en  <= 1'b0;
    end else begin
      r_scan_en  <= (r_scan_cnt == SCAN_LAST);
      r_scan_cnt <= (r_scan_cnt == SCAN_LAST) ? '0 : r_scan_cnt + 1'b1;
    end
  end

  assign w_cap_a     = a_valid & r_a_ready;
  assign w_cap_b     = b_valid & r_b_ready;
  assign w_pend_sel  = r_sel ? r_pend_b : r_pend_a;
  assign w_has_other = r_sel ? r_has_a : r_has_b;

  // A capture on the same edge as a switch-load of that source keeps the new
  // value pending; the load itself uses the previously held value.
  assign w_pend_a_next = w_cap_a | (r_pend_a & ~(w_load & ~w_load_src));
  assign w_pend_b_next = w_cap_b | (r_pend_b & ~(w_load &  w_load_src));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_src   = r_sel;
    w_dwell_next = r_dwell;
    case (r_state)
      ST_IDLE: begin
        if (r_pend_a) begin
          w_load     = 1'b1;
          w_load_src = 1'b0;
        end else if (r_pend_b) begin
          w_load     = 1'b1;
          w_load_src = 1'b1;
        end
      end
      ST_SHOW: begin
        if (r_scan_en) begin
          if (r_dwell == DWELL_LAST) begin
            w_dwell_next = '0;
            if (w_has_other) begin
              w_load     = 1'b1;
              w_load_src = ~r_sel;
            end
          end else begin
            w_dwell_next = r_dwell + 1'b1;
          end
        end else if (w_pend_sel) begin
          w_load     = 1'b1;
          w_load_src = r_sel;
        end
      end
      ST_CONV:   if (r_bit_cnt == 4'd13) w_state_next = ST_COMMIT;
      ST_COMMIT: w_state_next = ST_SHOW;
      default:   w_state_next = ST_IDLE;
    endcase
    if (w_load) w_state_next = ST_CONV;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_val_a   <= '0;
      r_val_b   <= '0;
      r_pend_a  <= 1'b0;
      r_pend_b  <= 1'b0;
      r_has_a   <= 1'b0;
      r_has_b   <= 1'b0;
      r_a_ready <= 1'b1;
      r_b_ready <= 1'b1;
      r_sel     <= 1'b0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_dwell   <= '0;
      r_digits  <= '0;
      r_colon   <= 2'b11;
      r_src     <= 1'b0;
    end else begin
      r_pend_a  <= w_pend_a_next;
      r_pend_b  <= w_pend_b_next;
      r_a_ready <= ~w_pend_a_next;
      r_b_ready <= ~w_pend_b_next;
      r_dwell   <= w_dwell_next;
      if (w_cap_a) begin
        r_val_a <= (a_value > VAL_MAX) ? VAL_MAX : a_value;
        r_has_a <= 1'b1;
      end
      if (w_cap_b) begin
        r_val_b <= (b_value > VAL_MAX) ? VAL_MAX : b_value;
        r_has_b <= 1'b1;
      end
      if (w_load) begin
        r_shift   <= {16'b0, w_load_src ? r_val_b : r_val_a};
        r_sel     <= w_load_src;
        r_bit_cnt <= '0;
      end else if (r_state == ST_CONV) begin
        r_shift   <= f_dd_step(r_shift);
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (r_state == ST_COMMIT) begin
        r_digits <= r_shift[29:14];
        r_colon  <= r_sel ? 2'b01 : 2'b11;
        r_src    <= r_sel;
      end
    end
  end

  assign a_ready     = r_a_ready;
  assign b_ready     = r_b_ready;
  assign scan_enable = r_scan_en;
  assign digit0      = r_digits[3:0];
  assign digit1      = r_digits[7:4];
  assign digit2      = r_digits[11:8];
  assign digit3      = r_digits[15:12];
  assign colon       = r_colon;
  assign src         = r_src;
  assign busy        = (r_state == ST_CONV) || (r_state == ST_COMMIT);

endmodule

// File: tb/tb_seg7_display_sched.sv
// Bench for seg7_display_sched: table of single conversions, hand sequences for
// timing corners, then random traffic against a timestamp-based display model.
module tb_seg7_display_sched;

  localparam int SCAN  = 40;
  localparam int DWELL = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [13:0] a_value = '0, b_value = '0;
  logic        a_ready, b_ready, scan_enable, src, busy;
  logic [3:0]  digit0, digit1, digit2, digit3;
  logic [1:0]  colon;

  seg7_display_sched #(.SCAN_DIV(SCAN), .DWELL_SCANS(DWELL)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_value(a_value), .a_ready(a_ready),
    .b_valid(b_valid), .b_value(b_value), .b_ready(b_ready),
    .scan_enable(scan_enable),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .colon(colon), .src(src), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] shown();
    return {digit3, digit2, digit1, digit0};
  endfunction

  // ---------------- reference model ----------------
  // Display state as the outside sees it; a conversion is a countdown that
  // publishes the decimal value when it expires.
  int m_edges, m_left, m_cval, m_disp, m_dwell;
  int m_val[2];
  bit m_pend[2], m_has[2];
  bit m_scan, m_src, m_csrc, m_started, m_sel;

  task automatic m_reset();
    m_edges = 0; m_scan = 0; m_left = 0; m_cval = 0; m_csrc = 0;
    m_disp = 0; m_src = 0; m_started = 0; m_sel = 0; m_dwell = 0;
    for (int i = 0; i < 2; i++) begin m_val[i] = 0; m_pend[i] = 0; m_has[i] = 0; end
  endtask

  task automatic m_step(input bit rst, input bit av, input int aval, input bit bv, input int bval);
    bit cap[2];
    int ld;
    int vin[2];
    if (!rst) begin m_reset(); return; end
    cap[0] = av && !m_pend[0];
    cap[1] = bv && !m_pend[1];
    vin[0] = aval; vin[1] = bval;
    ld = -1;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_disp = m_cval; m_src = m_csrc; end
    end else if (!m_started) begin
      if (m_pend[0]) ld = 0; else if (m_pend[1]) ld = 1;
    end else if (m_scan) begin
      if (m_dwell == DWELL - 1) begin
        m_dwell = 0;
        if (m_has[!m_sel]) ld = m_sel ? 0 : 1;
      end else m_dwell++;
    end else if (m_pend[m_sel]) ld = m_sel;
    if (ld >= 0) begin
      m_cval = m_val[ld]; m_csrc = (ld == 1); m_left = 15;
      m_sel = (ld == 1); m_started = 1; m_pend[ld] = 0;
    end
    for (int i = 0; i < 2; i++)
      if (cap[i]) begin
        m_val[i] = (vin[i] > 9999) ? 9999 : vin[i];
        m_pend[i] = 1; m_has[i] = 1;
      end
    m_edges++;
    m_scan = (m_edges % SCAN == 0);
  endtask

  // ---------------- helpers ----------------
  task automatic reset_dut();
    @(negedge clk); rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_digits"}, shown(), 16'h0000);
    chk({tag, "_colon"}, colon, 2'b11);
    chk({tag, "_src"}, src, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_a_ready"}, a_ready, 1'b1);
    chk({tag, "_b_ready"}, b_ready, 1'b1);
    chk({tag, "_scan"}, scan_enable, 1'b0);
  endtask

  typedef struct {
    bit          srcb;
    logic [13:0] val;
    logic [15:0] exp_bcd;
    logic [1:0]  exp_colon;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v);
    int cnt;
    reset_dut();
    if (v.srcb) begin b_valid = 1'b1; b_value = v.val; end
    else        begin a_valid = 1'b1; a_value = v.val; end
    @(negedge clk);
    chk("vec_ready_low", v.srcb ? b_ready : a_ready, 1'b0);
    chk("vec_busy_e0", busy, 1'b0);
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    chk("vec_busy_e1", busy, 1'b1);
    chk("vec_ready_back", v.srcb ? b_ready : a_ready, 1'b1);
    cnt = 1;
    while (busy && cnt < 40) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("vec_busy_len", cnt, 15);
    chk("vec_digits", shown(), v.exp_bcd);
    chk("vec_colon", colon, v.exp_colon);
    chk("vec_src", src, v.srcb);
  endtask

  initial begin
    int toggles[$];
    int cyc, k;
    bit prev;

    vecs[0] = '{1'b0, 14'd1234,  16'h1234, 2'b11};
    vecs[1] = '{1'b0, 14'h3FFF,  16'h9999, 2'b11};
    vecs[2] = '{1'b1, 14'd0,     16'h0000, 2'b01};
    vecs[3] = '{1'b0, 14'd42,    16'h0042, 2'b11};
    vecs[4] = '{1'b1, 14'd250,   16'h0250, 2'b01};
    vecs[5] = '{1'b0, 14'd9999,  16'h9999, 2'b11};
    vecs[6] = '{1'b1, 14'd10000, 16'h9999, 2'b01};
    vecs[7] = '{1'b0, 14'd1,     16'h0001, 2'b11};
    vecs[8] = '{1'b1, 14'd9990,  16'h9990, 2'b01};
    vecs[9] = '{1'b0, 14'd5,     16'h0005, 2'b11};

    // Reset values and scan tick period.
    @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    for (int n = 1; n <= 125; n++) begin
      @(negedge clk);
      chk("scan_tick", scan_enable, (n % SCAN == 0));
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: second value held on a_valid is taken right after the load.
    reset_dut();
    a_valid = 1'b1; a_value = 14'd100;
    @(negedge clk);
    chk("bp_ready_e0", a_ready, 1'b0);
    a_value = 14'd200;
    @(negedge clk);
    chk("bp_ready_e1", a_ready, 1'b1);
    chk("bp_busy_e1", busy, 1'b1);
    @(negedge clk);
    chk("bp_ready_e2", a_ready, 1'b0);
    a_valid = 1'b0;
    k = 0;
    while (shown() != 16'h0100 && k < 40) begin @(negedge clk); k++; end
    chk("bp_first_shown", shown(), 16'h0100);
    k = 0;
    while (shown() != 16'h0200 && k < 60) begin @(negedge clk); k++; end
    chk("bp_second_shown", shown(), 16'h0200);
    @(negedge clk);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      chk("bp_no_dup_busy", busy, 1'b0);
      chk("bp_hold_src_a", src, 1'b0);
      chk("bp_hold_digits", shown(), 16'h0200);
    end

    // Reset in the middle of a conversion.
    reset_dut();
    a_valid = 1'b1; a_value = 14'd5678;
    @(negedge clk);
    a_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    rst_n = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      chk("midrst_quiet_busy", busy, 1'b0);
      chk("midrst_quiet_digits", shown(), 16'h0000);
      chk("midrst_quiet_src", src, 1'b0);
    end

    // Dwell switching between A=42 and B=250.
    reset_dut();
    a_valid = 1'b1; a_value = 14'd42;
    @(negedge clk);
    a_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("dwell_a_first", shown(), 16'h0042);
    b_valid = 1'b1; b_value = 14'd250;
    @(negedge clk);
    b_valid = 1'b0;
    prev = src;
    for (cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      chk("dwell_digits", shown(), src ? 16'h0250 : 16'h0042);
      chk("dwell_colon", colon, src ? 2'b01 : 2'b11);
      if (src != prev) toggles.push_back(cyc);
      prev = src;
    end
    chk("dwell_toggle_count", (toggles.size() >= 3), 1'b1);
    for (int i = 1; i < toggles.size(); i++)
      chk("dwell_period", toggles[i] - toggles[i-1], DWELL * SCAN);

    // Random traffic against the model.
    reset_dut();
    m_reset();
    for (int n = 0; n < 5000; n++) begin
      bit r, av, bv;
      int aval, bval;
      chk("rnd_scan", scan_enable, m_scan);
      chk("rnd_a_ready", a_ready, !m_pend[0]);
      chk("rnd_b_ready", b_ready, !m_pend[1]);
      chk("rnd_busy", busy, (m_left > 0));
      chk("rnd_digits", shown(), to_bcd(m_disp));
      chk("rnd_colon", colon, m_src ? 2'b01 : 2'b11);
      chk("rnd_src", src, m_src);
      r  = ($urandom_range(0, 999) != 0);
      av = ($urandom_range(0, 5) == 0);
      bv = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: aval = $urandom_range(0, 16383);
        1: aval = $urandom_range(0, 99);
        2: aval = $urandom_range(9990, 10010);
        default: aval = $urandom_range(0, 9999);
      endcase
      bval = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 16383) : $urandom_range(9995, 10005);
      rst_n = r; a_valid = av; b_valid = bv;
      a_value = 14'(aval); b_value = 14'(bval);
      m_step(r, av, aval, bv, bval);
      @(negedge clk);
    end
    rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
